// File: rtl/pwm_compare_unit.sv
// -----------------------------------------------------------------------------
// pwm_compare_unit
//
// Consumes the count value of an upstream counter and compares it against a
// double-buffered compare register to generate a registered PWM waveform,
// one-cycle match and period pulses, and a sticky interrupt flag. An
// IDLE/ARMED/RUN state machine makes the PWM start only on a clean period
// boundary, so the first period after arming is always a complete one.
//
// Ports:
//   clk          system clock, everything on the rising edge
//   rst          asynchronous, active-low reset
//   count_in     counter value (WIDTH bits)
//   count_valid  sample qualifier; count_in is ignored while low
//   cmp_wr       write strobe for the shadow compare register
//   cmp_data     compare value written on cmp_wr
//   arm          request start (IDLE -> ARMED)
//   disarm       request stop (any state -> IDLE), has priority over arm
//   irq_clr      clears irq (a simultaneous set wins)
//   pwm_out      registered PWM output
//   match_pulse  one-cycle pulse after a compare match
//   period_pulse one-cycle pulse after a period boundary seen while busy
//   irq          sticky match flag
//   cmp_active   compare value currently in effect
//   busy         high while in ARMED or RUN
// -----------------------------------------------------------------------------
module pwm_compare_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_valid,
    input  logic             cmp_wr,
    input  logic [WIDTH-1:0] cmp_data,
    input  logic             arm,
    input  logic             disarm,
    input  logic             irq_clr,
    output logic             pwm_out,
    output logic             match_pulse,
    output logic             period_pulse,
    output logic             irq,
    output logic [WIDTH-1:0] cmp_active,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] count_q_r;
    logic [WIDTH-1:0] cmp_shadow_r;
    logic [WIDTH-1:0] cmp_shadow_next_s;
    logic             pend_r;
    logic             pend_next_s;
    logic [WIDTH-1:0] cmp_active_r;
    logic [WIDTH-1:0] cmp_active_next_s;
    logic [WIDTH-1:0] cv_s;
    logic             boundary_s;
    logic             eval_s;
    logic             pwm_r;
    logic             pwm_next_s;
    logic             match_r;
    logic             match_next_s;
    logic             period_r;
    logic             period_next_s;
    logic             irq_r;
    logic             irq_next_s;
    logic             busy_r;

    // Period boundary: a valid sample arriving at zero from a non-zero value.
    // Requiring count_q != 0 keeps a counter parked at zero from re-firing.
    always_comb begin
        boundary_s = 1'b0;
        if (count_valid && (count_in == ZERO_W) && (count_q_r != ZERO_W)) begin
            boundary_s = 1'b1;
        end else begin
            boundary_s = 1'b0;
        end
    end

    // Double-buffered compare value: writes land in the shadow and are
    // promoted only at a boundary; a write coincident with a boundary goes
    // straight to the active register.
    always_comb begin
        cmp_shadow_next_s = cmp_shadow_r;
        pend_next_s       = pend_r;
        cmp_active_next_s = cmp_active_r;
        if (cmp_wr) begin
            cmp_shadow_next_s = cmp_data;
        end else begin
            cmp_shadow_next_s = cmp_shadow_r;
        end
        if (boundary_s) begin
            pend_next_s = 1'b0;
            if (cmp_wr) begin
                cmp_active_next_s = cmp_data;
            end else if (pend_r) begin
                cmp_active_next_s = cmp_shadow_r;
            end else begin
                cmp_active_next_s = cmp_active_r;
            end
        end else if (cmp_wr) begin
            pend_next_s       = 1'b1;
            cmp_active_next_s = cmp_active_r;
        end else begin
            pend_next_s       = pend_r;
            cmp_active_next_s = cmp_active_r;
        end
    end

    // The value compared on this edge is the one cmp_active holds after it,
    // so the first sample of a new period already uses the new compare.
    assign cv_s = cmp_active_next_s;

    // Arm/disarm state machine: next-state logic, disarm dominates.
    always_comb begin
        state_next_s = state_r;
        if (disarm) begin
            state_next_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (arm) begin
                        state_next_s = ST_ARMED;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ARMED: begin
                    if (boundary_s) begin
                        state_next_s = ST_RUN;
                    end else begin
                        state_next_s = ST_ARMED;
                    end
                end
                ST_RUN: begin
                    state_next_s = ST_RUN;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Compare evaluation happens on valid samples in RUN, including the
    // ARMED->RUN edge; RUN is only entered or kept when disarm is low.
    always_comb begin
        eval_s = 1'b0;
        if (count_valid && (state_next_s == ST_RUN)) begin
            eval_s = 1'b1;
        end else begin
            eval_s = 1'b0;
        end
    end

    // Output next values: PWM level, match/period pulses and sticky irq.
    always_comb begin
        pwm_next_s    = pwm_r;
        match_next_s  = 1'b0;
        period_next_s = 1'b0;
        irq_next_s    = irq_r;
        if (state_next_s == ST_IDLE) begin
            pwm_next_s = 1'b0;
        end else if (eval_s) begin
            pwm_next_s = (count_in < cv_s);
        end else begin
            pwm_next_s = pwm_r;
        end
        // count_in != count_q suppresses repeated matches in hold mode.
        if (eval_s && (count_in == cv_s) && (count_in != count_q_r)) begin
            match_next_s = 1'b1;
        end else begin
            match_next_s = 1'b0;
        end
        if (boundary_s && !disarm && (state_r != ST_IDLE)) begin
            period_next_s = 1'b1;
        end else begin
            period_next_s = 1'b0;
        end
        // A set coincident with a clear wins.
        if (match_next_s) begin
            irq_next_s = 1'b1;
        end else if (irq_clr) begin
            irq_next_s = 1'b0;
        end else begin
            irq_next_s = irq_r;
        end
    end

    // State register; busy is tracked alongside so it is a clean flop output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_next_s;
            busy_r  <= (state_next_s != ST_IDLE);
        end
    end

    // Last valid counter sample, held while count_valid is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q_r <= ZERO_W;
        end else if (count_valid) begin
            count_q_r <= count_in;
        end else begin
            count_q_r <= count_q_r;
        end
    end

    // Compare shadow/active registers and the pending-transfer flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmp_shadow_r <= ZERO_W;
            pend_r       <= 1'b0;
            cmp_active_r <= ZERO_W;
        end else begin
            cmp_shadow_r <= cmp_shadow_next_s;
            pend_r       <= pend_next_s;
            cmp_active_r <= cmp_active_next_s;
        end
    end

    // Registered PWM, pulse and interrupt outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pwm_r    <= 1'b0;
            match_r  <= 1'b0;
            period_r <= 1'b0;
            irq_r    <= 1'b0;
        end else begin
            pwm_r    <= pwm_next_s;
            match_r  <= match_next_s;
            period_r <= period_next_s;
            irq_r    <= irq_next_s;
        end
    end

    assign pwm_out      = pwm_r;
    assign match_pulse  = match_r;
    assign period_pulse = period_r;
    assign irq          = irq_r;
    assign cmp_active   = cmp_active_r;
    assign busy         = busy_r;

endmodule

// File: tb/tb_pwm_compare_unit.sv
module tb_pwm_compare_unit;

    logic       clk;
    logic       rst;
    logic [7:0] count_in;
    logic       count_valid;
    logic       cmp_wr;
    logic [7:0] cmp_data;
    logic       arm;
    logic       disarm;
    logic       irq_clr;
    logic       pwm_out;
    logic       match_pulse;
    logic       period_pulse;
    logic       irq;
    logic [7:0] cmp_active;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int step_no = 0;

    typedef struct {
        logic       v;
        logic [7:0] c;
        logic       wr;
        logic [7:0] d;
        logic       a;
        logic       da;
        logic       clr;
        logic       e_pwm;
        logic       e_match;
        logic       e_period;
        logic       e_irq;
        logic       e_busy;
        logic [7:0] e_cmp;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[$];

    pwm_compare_unit #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .count_in(count_in), .count_valid(count_valid),
        .cmp_wr(cmp_wr), .cmp_data(cmp_data), .arm(arm), .disarm(disarm),
        .irq_clr(irq_clr), .pwm_out(pwm_out), .match_pulse(match_pulse),
        .period_pulse(period_pulse), .irq(irq), .cmp_active(cmp_active),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic v, input logic [7:0] c,
                                input logic wr, input logic [7:0] d,
                                input logic a, input logic da, input logic clr,
                                input logic pwm, input logic m, input logic p,
                                input logic ir, input logic bz,
                                input logic [7:0] cmp);
        vec_t x;
        x.v = v; x.c = c; x.wr = wr; x.d = d; x.a = a; x.da = da; x.clr = clr;
        x.e_pwm = pwm; x.e_match = m; x.e_period = p; x.e_irq = ir;
        x.e_busy = bz; x.e_cmp = cmp;
        return x;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s (step %0d): got %0h, expected %0h", name, step_no, act, want);
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".pwm_out"},      {7'd0, pwm_out},      8'h00);
        chk({tag, ".match_pulse"},  {7'd0, match_pulse},  8'h00);
        chk({tag, ".period_pulse"}, {7'd0, period_pulse}, 8'h00);
        chk({tag, ".irq"},          {7'd0, irq},          8'h00);
        chk({tag, ".busy"},         {7'd0, busy},         8'h00);
        chk({tag, ".cmp_active"},   cmp_active,           8'h00);
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input vec_t x);
        vec_t e;
        count_valid = x.v; count_in = x.c; cmp_wr = x.wr; cmp_data = x.d;
        arm = x.a; disarm = x.da; irq_clr = x.clr;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        step_no++;
        e = exp_q.pop_front();
        chk("pwm_out",      {7'd0, pwm_out},      {7'd0, e.e_pwm});
        chk("match_pulse",  {7'd0, match_pulse},  {7'd0, e.e_match});
        chk("period_pulse", {7'd0, period_pulse}, {7'd0, e.e_period});
        chk("irq",          {7'd0, irq},          {7'd0, e.e_irq});
        chk("busy",         {7'd0, busy},         {7'd0, e.e_busy});
        chk("cmp_active",   cmp_active,           e.e_cmp);
    endtask

    initial begin
        // Hold-mode, down-mode and pre-reset vectors (tests 4..6 setup).
        // hold at 0x40: match once; irq_clr on the matching sample loses to set
        tbl.push_back(mk(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40));
        for (int i = 0; i < 9; i++)
            tbl.push_back(mk(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40));
        tbl.push_back(mk(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40));
        // down counting 3,2,1,0: boundary on 1->0
        tbl.push_back(mk(1'b1, 8'h03, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40));
        tbl.push_back(mk(1'b1, 8'h02, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40));
        tbl.push_back(mk(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40));
        tbl.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h40));
        // count_valid low: pwm frozen high, no match even though count_in==cv
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(1'b0, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40));
        tbl.push_back(mk(1'b1, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h40));
        // wrap, match, then pwm high with irq set
        tbl.push_back(mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h40));
        tbl.push_back(mk(1'b1, 8'h40, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40));
        tbl.push_back(mk(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h40));

        rst = 1'b0; count_in = 8'h00; count_valid = 1'b0; cmp_wr = 1'b0;
        cmp_data = 8'h00; arm = 1'b0; disarm = 1'b0; irq_clr = 1'b0;
        #3;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b1;

        // Test 1: arm and load 0x40, first period is not driven.
        step(mk(1'b1, 8'h00, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        for (int c = 1; c < 256; c++)
            step(mk(1'b1, 8'(c), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        // First RUN period with cv=0x40; write 0x80 mid-period (test 2).
        for (int c = 0; c < 256; c++)
            step(mk(1'b1, 8'(c), (c == 16), 8'h80, 1'b0, 1'b0, 1'b0,
                    (c < 64), (c == 64), (c == 0), (c >= 64), 1'b1, 8'h40));
        // Period with cv=0x80.
        for (int c = 0; c < 256; c++)
            step(mk(1'b1, 8'(c), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                    (c < 128), (c == 128), (c == 0), 1'b1, 1'b1, 8'h80));
        // Test 3: write 0x20 on the boundary, queue 0x40, clear irq at 0x30.
        for (int c = 0; c < 256; c++)
            step(mk(1'b1, 8'(c), (c == 0) || (c == 16), (c == 0) ? 8'h20 : 8'h40,
                    1'b0, 1'b0, (c == 48),
                    (c < 32), (c == 32), (c == 0), (c < 48), 1'b1, 8'h20));
        // Period with cv=0x40 up to just before the hold value.
        for (int c = 0; c < 64; c++)
            step(mk(1'b1, 8'(c), 1'b0, 8'h00, 1'b0, 1'b0, 1'b0,
                    1'b1, 1'b0, (c == 0), 1'b0, 1'b1, 8'h40));

        // Tests 4 and 5 plus setup for test 6.
        foreach (tbl[i]) step(tbl[i]);

        // Test 6: asynchronous reset mid-period with irq=1 and pwm_out=1.
        count_valid = 1'b0; irq_clr = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        // No activity without a new arm, even across a boundary.
        step(mk(1'b1, 8'h05, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        step(mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        // arm together with disarm stays IDLE.
        step(mk(1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        step(mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00));
        // Arm with cv=0: pwm stays low; count 0 still matches a zero compare.
        step(mk(1'b1, 8'h05, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00));
        step(mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00));
        step(mk(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        // Shadow transfer still happens at a boundary while IDLE.
        step(mk(1'b1, 8'h05, 1'b1, 8'h10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00));
        step(mk(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h10));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
